// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: host UART debug bridge that runs single-byte
// reads/writes on the system memory bus after winning hold_req/hold_ack.
// Ports:
//   clk_in, b_reset (async, active-low)
//   brx/btx      8N1 serial from/to host, idle high
//   hold_req/ack bus request to arbiter / grant (CPU stalled)
//   bus_ad/do/di address, write data, read data
//   bus_rw/cs    1=read 0=write, access strobe
//   busy         command in progress until reply stop bit is sent
module uart_bus_bridge #(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int BUS_CYCLES = 16,
  parameter int TIMEOUT    = 240000
) (
  input  logic        clk_in,
  input  logic        b_reset,
  input  logic        brx,
  output logic        btx,
  output logic        hold_req,
  input  logic        hold_ack,
  output logic [15:0] bus_ad,
  output logic [7:0]  bus_do,
  input  logic [7:0]  bus_di,
  output logic        bus_rw,
  output logic        bus_cs,
  output logic        busy
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int AW   = $clog2(BUS_CYCLES + 1);

  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_Q = 8'h3F;

  typedef enum logic [2:0] {
    P_IDLE, P_AH, P_AL, P_DAT,
    P_GRANT, P_ACCESS, P_RESP, P_DRAIN
  } pst_t;

  pst_t st, st_nx;

  // ---------------- receiver ----------------
  logic          rx_s1, rx_s2, rx_s3;
  logic          rx_act;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_vld, rx_ferr;

  // rx_bit 0 = start-bit check, 1..8 = data, 9 = stop
  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_s3   <= 1'b1;
      rx_act  <= 1'b0;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_s1   <= brx;
      rx_s2   <= rx_s1;
      rx_s3   <= rx_s2;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      if (!rx_act) begin
        if (rx_s3 && !rx_s2) begin
          rx_act <= 1'b1;
          rx_cnt <= '0;
          rx_bit <= '0;
        end
      end else if (rx_bit == 4'd0) begin
        rx_cnt <= rx_cnt + CW'(1);
        if (rx_cnt == CW'(HALF - 1)) begin
          rx_cnt <= '0;
          if (rx_s2) rx_act <= 1'b0;
          else       rx_bit <= 4'd1;
        end
      end else begin
        rx_cnt <= rx_cnt + CW'(1);
        if (rx_cnt == CW'(DIV - 1)) begin
          rx_cnt <= '0;
          if (rx_bit == 4'd9) begin
            rx_act  <= 1'b0;
            rx_vld  <= rx_s2;
            rx_ferr <= !rx_s2;
          end else begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 4'd1;
          end
        end
      end
    end
  end

  // ---------------- transmitter ----------------
  logic          tx_busy;
  logic [9:0]    tx_sh;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic          tx_load;
  logic [7:0]    tx_byte;

  // shift register refills with ones, so bit 0 is the idle-high line
  assign btx = tx_sh[0];

  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      tx_sh   <= '1;
      tx_busy <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
    end else if (!tx_busy) begin
      if (tx_load) begin
        tx_sh   <= {1'b1, tx_byte, 1'b0};
        tx_busy <= 1'b1;
        tx_cnt  <= '0;
        tx_bit  <= '0;
      end
    end else if (tx_cnt == CW'(DIV - 1)) begin
      tx_cnt <= '0;
      tx_sh  <= {1'b1, tx_sh[9:1]};
      if (tx_bit == 4'd9) tx_busy <= 1'b0;
      else                tx_bit  <= tx_bit + 4'd1;
    end else begin
      tx_cnt <= tx_cnt + CW'(1);
    end
  end

  // ---------------- command parser ----------------
  logic          op_rd;
  logic [TW-1:0] to_cnt;
  logic [AW-1:0] acc_cnt;
  logic [7:0]    rd_data;
  logic          q_pend;
  logic          is_cmd, to_hit, acc_last, wait_byte;
  logic          bad_byte;

  assign is_cmd    = (rx_sh == CH_R) || (rx_sh == CH_W);
  assign to_hit    = to_cnt == TW'(TIMEOUT - 1);
  assign acc_last  = acc_cnt == AW'(BUS_CYCLES - 1);
  assign wait_byte = (st == P_AH) || (st == P_AL)
                  || (st == P_DAT);
  assign bad_byte  = (st == P_IDLE) && rx_vld && !is_cmd;

  always_comb begin
    st_nx   = st;
    tx_load = 1'b0;
    tx_byte = CH_Q;
    unique case (st)
      P_IDLE:
        if (rx_vld && is_cmd) st_nx = P_AH;
      P_AH:
        if (rx_ferr || to_hit) st_nx = P_IDLE;
        else if (rx_vld)       st_nx = P_AL;
      P_AL:
        if (rx_ferr || to_hit) st_nx = P_IDLE;
        else if (rx_vld)       st_nx = op_rd ? P_GRANT : P_DAT;
      P_DAT:
        if (rx_ferr || to_hit) st_nx = P_IDLE;
        else if (rx_vld)       st_nx = P_GRANT;
      P_GRANT:
        if (hold_ack) st_nx = P_ACCESS;
      P_ACCESS:
        if (acc_last) st_nx = P_RESP;
      P_RESP:
        if (!tx_busy) begin
          tx_load = 1'b1;
          tx_byte = op_rd ? rd_data : CH_K;
          st_nx   = P_DRAIN;
        end
      P_DRAIN:
        if (!tx_busy) st_nx = P_IDLE;
      default:
        st_nx = P_IDLE;
    endcase
    // a queued '?' goes out whenever the reply path is not using TX
    if (!tx_busy && st != P_RESP && q_pend) begin
      tx_load = 1'b1;
      tx_byte = CH_Q;
    end
  end

  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      st       <= P_IDLE;
      busy     <= 1'b0;
      hold_req <= 1'b0;
      bus_cs   <= 1'b0;
      bus_rw   <= 1'b1;
      bus_ad   <= '0;
      bus_do   <= '0;
      op_rd    <= 1'b1;
      to_cnt   <= '0;
      acc_cnt  <= '0;
      rd_data  <= '0;
      q_pend   <= 1'b0;
    end else begin
      st       <= st_nx;
      busy     <= st_nx != P_IDLE;
      hold_req <= (st_nx == P_GRANT) || (st_nx == P_ACCESS);
      bus_cs   <= st_nx == P_ACCESS;
      bus_rw   <= !((st_nx == P_ACCESS) && !op_rd);

      if (st == P_IDLE && rx_vld && is_cmd)
        op_rd <= rx_sh == CH_R;
      if (st == P_AH && rx_vld)  bus_ad[15:8] <= rx_sh;
      if (st == P_AL && rx_vld)  bus_ad[7:0]  <= rx_sh;
      if (st == P_DAT && rx_vld) bus_do       <= rx_sh;

      if (rx_vld || !wait_byte) to_cnt <= '0;
      else                      to_cnt <= to_cnt + TW'(1);

      if (st == P_ACCESS) acc_cnt <= acc_cnt + AW'(1);
      else                acc_cnt <= '0;

      if (st == P_ACCESS && acc_last) rd_data <= bus_di;

      // one '?' may wait behind the current byte; more are dropped
      if (bad_byte)
        q_pend <= 1'b1;
      else if (tx_load && st != P_RESP)
        q_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed bench for uart_bus_bridge.
// Vector table for whole frames plus hand sequences for corner cases.
module tb_uart_bus_bridge;

  localparam int DIV = 16;
  localparam int TMO = 2000;

  logic        clk;
  logic        b_reset;
  logic        brx;
  logic        btx;
  logic        hold_req;
  logic        hold_ack;
  logic [15:0] bus_ad;
  logic [7:0]  bus_do;
  logic [7:0]  bus_di;
  logic        bus_rw;
  logic        bus_cs;
  logic        busy;

  uart_bus_bridge #(
    .CLK_HZ(1600000),
    .BAUD(100000),
    .BUS_CYCLES(16),
    .TIMEOUT(TMO)
  ) dut (
    .clk_in(clk),
    .b_reset(b_reset),
    .brx(brx),
    .btx(btx),
    .hold_req(hold_req),
    .hold_ack(hold_ack),
    .bus_ad(bus_ad),
    .bus_do(bus_do),
    .bus_di(bus_di),
    .bus_rw(bus_rw),
    .bus_cs(bus_cs),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // arbiter model: grant follows request one cycle later
  logic ack_en;
  always @(posedge clk) hold_ack <= ack_en & hold_req & b_reset;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // bus observer, sampled on the falling edge
  int          cyc = 0;
  int          acc_count = 0;
  int          cs_rises = 0;
  int          hr_rises = 0;
  int          viol = 0;
  int          cur_len = 0;
  int          last_len = 0;
  int          cs_rise_cyc = 0;
  int          ack_rise_cyc = 0;
  logic [15:0] last_ad;
  logic [7:0]  last_do;
  logic        last_rw;
  logic        hr_after, rw_after;
  logic        cs_prev = 1'b0;
  logic        hr_prev = 1'b0;
  logic        ack_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (hold_req && !hr_prev) hr_rises++;
    if (hold_ack && !ack_prev) ack_rise_cyc = cyc;
    if (bus_cs) begin
      if (!cs_prev) begin
        cur_len = 0;
        cs_rises++;
        cs_rise_cyc = cyc;
      end
      cur_len++;
      if (!(hold_req && hold_ack)) viol++;
      last_ad = bus_ad;
      last_do = bus_do;
      last_rw = bus_rw;
    end else if (cs_prev) begin
      last_len = cur_len;
      acc_count++;
      hr_after = hold_req;
      rw_after = bus_rw;
    end
    cs_prev  = bus_cs;
    hr_prev  = hold_req;
    ack_prev = hold_ack;
  end

  // independent 8N1 decoder on btx
  logic [7:0] rxq[$];

  initial begin : rx_mon
    logic [7:0] b;
    forever begin
      @(negedge btx);
      repeat (DIV / 2) @(posedge clk);
      if (btx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(posedge clk);
          b[i] = btx;
        end
        repeat (DIV) @(posedge clk);
        rxq.push_back(b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop);
    @(negedge clk);
    brx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      brx = b[i];
      repeat (DIV) @(negedge clk);
    end
    brx = stop;
    repeat (DIV) @(negedge clk);
    brx = 1'b1;
  endtask

  task automatic wait_resp(output logic [7:0] b, output bit ok);
    ok = 1'b0;
    b  = 8'h00;
    for (int i = 0; i < 40 * DIV + 500 && !ok; i++) begin
      @(negedge clk);
      if (rxq.size() > 0) begin
        b  = rxq.pop_front();
        ok = 1'b1;
      end
    end
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          n;
    logic [7:0]  di;
    logic [15:0] ad;
    logic [7:0]  dout;
    logic        rw;
    logic [7:0]  resp;
    logic        acc;
  } vec_t;

  vec_t vt[7];

  initial begin : main
    logic [7:0] r;
    bit         ok;
    int         a0, c0, h0;

    vt[0] = '{32'h571234A5, 4, 8'h00, 16'h1234, 8'hA5, 1'b0, 8'h4B, 1'b1};
    vt[1] = '{32'h52E6A000, 3, 8'h5C, 16'hE6A0, 8'h00, 1'b1, 8'h5C, 1'b1};
    vt[2] = '{32'h58000000, 1, 8'h00, 16'h0000, 8'h00, 1'b1, 8'h3F, 1'b0};
    vt[3] = '{32'h57FFFF00, 4, 8'h00, 16'hFFFF, 8'h00, 1'b0, 8'h4B, 1'b1};
    vt[4] = '{32'h52000000, 3, 8'hFF, 16'h0000, 8'h00, 1'b1, 8'hFF, 1'b1};
    vt[5] = '{32'h00000000, 1, 8'h00, 16'h0000, 8'h00, 1'b1, 8'h3F, 1'b0};
    vt[6] = '{32'h72000000, 1, 8'h00, 16'h0000, 8'h00, 1'b1, 8'h3F, 1'b0};

    b_reset = 1'b0;
    brx     = 1'b1;
    bus_di  = 8'h00;
    ack_en  = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_btx", btx, 1);
    chk("rst_hold_req", hold_req, 0);
    chk("rst_bus_cs", bus_cs, 0);
    chk("rst_bus_rw", bus_rw, 1);
    chk("rst_bus_ad", bus_ad, 0);
    chk("rst_bus_do", bus_do, 0);
    chk("rst_busy", busy, 0);
    b_reset = 1'b1;
    repeat (4) @(negedge clk);

    // whole frames from the table
    for (int v = 0; v < 7; v++) begin
      bus_di = vt[v].di;
      a0 = acc_count;
      for (int k = 0; k < vt[v].n; k++)
        send_byte(vt[v].bytes[31 - 8 * k -: 8], 1'b1);
      chk("busy_after_cmd", busy, vt[v].acc);
      wait_resp(r, ok);
      chk("resp_seen", ok, 1);
      chk("resp_byte", r, vt[v].resp);
      chk("access_count", acc_count - a0, vt[v].acc);
      if (vt[v].acc) begin
        chk("bus_ad", last_ad, vt[v].ad);
        chk("bus_rw", last_rw, vt[v].rw);
        chk("cs_len", last_len, 16);
        chk("hold_req_after_cs", hr_after, 0);
        chk("rw_after_cs", rw_after, 1);
        if (!vt[v].rw) chk("bus_do", last_do, vt[v].dout);
      end
      repeat (DIV) @(negedge clk);
      chk("busy_end", busy, 0);
      chk("cs_without_grant", viol, 0);
    end

    // grant withheld for 1000 cycles
    ack_en = 1'b0;
    bus_di = 8'h3C;
    c0 = cs_rises;
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    repeat (1000) @(negedge clk);
    chk("no_cs_without_ack", cs_rises - c0, 0);
    chk("hold_req_waiting", hold_req, 1);
    chk("busy_waiting", busy, 1);
    ack_en = 1'b1;
    wait_resp(r, ok);
    chk("late_resp", r, 8'h3C);
    chk("cs_after_ack", cs_rise_cyc - ack_rise_cyc, 1);
    chk("late_ad", last_ad, 16'h0010);
    chk("late_len", last_len, 16);

    // bad stop bit: byte dropped, parser stays idle
    send_byte(8'h52, 1'b0);
    repeat (30 * DIV) @(negedge clk);
    chk("ferr_busy", busy, 0);
    chk("ferr_no_resp", rxq.size(), 0);
    send_byte(8'h52, 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (4 * DIV) @(negedge clk);
    chk("ferr_mid_busy", busy, 0);
    bus_di = 8'h77;
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    wait_resp(r, ok);
    chk("ferr_next_resp", r, 8'h77);

    // inter-byte timeout
    h0 = hr_rises;
    send_byte(8'h57, 1'b1);
    send_byte(8'h12, 1'b1);
    repeat (TMO - 100) @(negedge clk);
    chk("tmo_busy_before", busy, 1);
    repeat (200) @(negedge clk);
    chk("tmo_busy_after", busy, 0);
    chk("tmo_no_hold_req", hr_rises - h0, 0);
    chk("tmo_no_resp", rxq.size(), 0);
    bus_di = 8'h9A;
    send_byte(8'h52, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    wait_resp(r, ok);
    chk("tmo_next_resp", r, 8'h9A);
    chk("tmo_next_ad", last_ad, 16'h1234);

    // reset in the middle of an access
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h11, 1'b1);
    for (int i = 0; i < 400 && !bus_cs; i++) @(negedge clk);
    chk("rst_cs_seen", bus_cs, 1);
    repeat (5) @(negedge clk);
    b_reset = 1'b0;
    #1;
    chk("arst_bus_cs", bus_cs, 0);
    chk("arst_hold_req", hold_req, 0);
    chk("arst_btx", btx, 1);
    chk("arst_busy", busy, 0);
    repeat (3) @(negedge clk);
    b_reset = 1'b1;
    repeat (40 * DIV) @(negedge clk);
    chk("arst_no_resp", rxq.size(), 0);
    bus_di = 8'h11;
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h20, 1'b1);
    wait_resp(r, ok);
    chk("arst_next_resp", r, 8'h11);
    chk("arst_next_len", last_len, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1);
  end

endmodule
